alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIORITY, default 0, meaning 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  operation of requester N accepted this cycle.
REQ-006 req0_in1, req0_in2, req1_in1, req1_in2  input  32 each  operands.
REQ-007 req0_func, req1_func  input  3 each  ALU function code, same encoding as the core ALU.
REQ-008 req0_func_sel, req1_func_sel  input  1 each  ALU variant select: SUB, SRA, CLR.
REQ-009 rsp_valid  output  1  result register holds a result.
REQ-010 rsp_ready  input  1  consumer takes the result this cycle.
REQ-011 rsp_data  output  32  registered ALU result.
REQ-012 rsp_id  output  1  index of the requester that issued rsp_data.

Function
REQ-013 Block SHALL contain one combinational ALU instance; its results SHALL match the core ALU for all func/func_sel codes: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND/CLR; shift amount = in2[4:0].
REQ-014 Result register states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-015 can_accept = EMPTY or (FULL and rsp_ready).
REQ-016 At most one reqN_ready SHALL be high per cycle; reqN_ready = can_accept and grant==N and reqN_valid.
REQ-017 Round-robin: if both valid, grant the requester not granted last; if one valid, grant it; last_grant updates only on an accepted transfer.
REQ-018 FIXED_PRIORITY=1: grant requester 0 whenever req0_valid, else requester 1.
REQ-019 Accepted transfer at edge k: rsp_data = ALU(granted operands), rsp_id = grant, rsp_valid = 1 from edge k; latency 1 cycle.
REQ-020 FULL and rsp_ready and no accept: go EMPTY at next edge.
REQ-021 FULL and rsp_ready and accept, same cycle: stay FULL with the new result; no bubble; sustained throughput 1 op/cycle.
REQ-022 FULL and not rsp_ready: rsp_data, rsp_id, rsp_valid SHALL hold stable; both reqN_ready = 0.
REQ-023 Requesters SHALL keep operands stable while valid and not ready; the arbiter SHALL NOT require valid to wait for ready.
REQ-024 Grant SHALL be combinational from current inputs and last_grant; a withdrawn valid with no accept SHALL NOT change last_grant.
REQ-025 Arithmetic: all 32-bit wrap-around; SLT/SLTU produce 0 or 1 in bit 0.

Reset
REQ-026 While reset=0: rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (so requester 0 wins the first contention), req0_ready=req1_ready=0.
REQ-027 Reset asserted mid-operation SHALL immediately discard any held result; no response SHALL issue for it after reset release.
REQ-028 First accept possible on the first rising edge after reset deasserts.

Verification
REQ-029 After reset, req0 valid: ADD, 0xFFFFFFFF + 0x00000001; rsp_ready=1 -> req0_ready=1; next cycle rsp_valid=1, rsp_data=0x00000000, rsp_id=0.
REQ-030 Both valid every cycle, rsp_ready=1, FIXED_PRIORITY=0 -> grants alternate 0,1,0,1; rsp_valid high every cycle after the first; rsp_id alternates.
REQ-031 FULL with rsp_ready=0 for 3 cycles; req1 valid with SRA, func_sel=1, 0x80000000 >> 4 -> req1_ready=0 while stalled; output held; on rsp_ready=1, req1 is accepted same cycle; next rsp_data=0xF8000000, rsp_id=1.
REQ-032 SLT 0xFFFFFFFF vs 1 -> rsp_data=1; SLTU same operands -> 0; CLR, func_sel=1, in1=0x0F, in2=0xFF -> 0xF0; SUB 5-7 -> 0xFFFFFFFE.
REQ-033 FIXED_PRIORITY=1, both valid continuously -> req1_ready never asserts; drop req0_valid -> req1 accepted next cycle.
REQ-034 Assert reset while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately, asynchronous; after release, no stale response appears.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two requesters share one combinational ALU. A single result register
//   (EMPTY/FULL) holds the registered result together with the index of the
//   requester that produced it. Arbitration is round-robin by default, or
//   fixed priority (requester 0 always wins) when FIXED_PRIORITY = 1.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous reset, active low
//   req0_valid/req1_valid  requester N presents an operation
//   req0_ready/req1_ready  operation of requester N accepted this cycle
//   reqN_in1, reqN_in2     32-bit operands
//   reqN_func              3-bit ALU function code
//   reqN_func_sel          variant select (SUB / SRA / CLR)
//   rsp_valid              result register holds a result
//   rsp_ready              consumer takes the result this cycle
//   rsp_data               registered ALU result
//   rsp_id                 requester index that issued rsp_data
module alu_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [2:0]  req0_func,
    input  logic        req0_func_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [2:0]  req1_func,
    input  logic        req1_func_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t  state;
    rsp_state_t  state_next;
    logic        last_grant;
    logic        grant;
    logic        can_accept;
    logic        accept;
    logic [31:0] op_in1;
    logic [31:0] op_in2;
    logic [2:0]  op_func;
    logic        op_sel;
    logic [31:0] alu_result;
    logic [4:0]  shamt;

    // Arbitration, handshake and next-state. Readies are gated by reset so
    // nothing is accepted while reset is held, even though the state is EMPTY.
    always_comb begin
        grant      = 1'b0;
        can_accept = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        state_next = state;

        if (FIXED_PRIORITY) begin
            grant = !req0_valid;
        end else if (req0_valid && req1_valid) begin
            grant = !last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end

        can_accept = reset && ((state == EMPTY) || rsp_ready);
        req0_ready = can_accept && !grant && req0_valid;
        req1_ready = can_accept &&  grant && req1_valid;
        accept     = req0_ready || req1_ready;

        if (accept) begin
            state_next = FULL;
        end else if (rsp_ready) begin
            state_next = EMPTY;
        end
    end

    // Operand mux feeding the single shared ALU.
    always_comb begin
        op_in1  = grant ? req1_in1      : req0_in1;
        op_in2  = grant ? req1_in2      : req0_in2;
        op_func = grant ? req1_func     : req0_func;
        op_sel  = grant ? req1_func_sel : req0_func_sel;
    end

    // Core ALU. CLR clears in2 bits that are set in in1 (~in1 & in2).
    always_comb begin
        shamt      = op_in2[4:0];
        alu_result = 32'd0;
        case (op_func)
            3'b000: alu_result = op_sel ? (op_in1 - op_in2) : (op_in1 + op_in2);
            3'b001: alu_result = op_in1 << shamt;
            3'b010: alu_result = {31'd0, $signed(op_in1) < $signed(op_in2)};
            3'b011: alu_result = {31'd0, op_in1 < op_in2};
            3'b100: alu_result = op_in1 ^ op_in2;
            3'b101: alu_result = op_sel ? $unsigned($signed(op_in1) >>> shamt)
                                        : (op_in1 >> shamt);
            3'b110: alu_result = op_in1 | op_in2;
            3'b111: alu_result = op_sel ? (~op_in1 & op_in2) : (op_in1 & op_in2);
            default: alu_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention; it
    // only moves on an accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data   <= 32'd0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_data   <= alu_result;
            rsp_id     <= grant;
            last_grant <= grant;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule
